// File: rtl/sw_seq_pkg.sv
// Shared types and defaults for the push-button bring-up sequencer.
// Holds the state encoding, default cycle counts and the state-to-output decode.
package sw_seq_pkg;

  localparam int DEBOUNCE_CYC_DEF = 64;
  localparam int AUTO_RST_CYC_DEF = 16;
  localparam int ASIC_RST_CYC_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_AUTO_RST = 3'd1,
    ST_WAIT_RST = 3'd2,
    ST_ASIC_RST = 3'd3,
    ST_WAIT_CLK = 3'd4,
    ST_RUN      = 3'd5,
    ST_HALT     = 3'd6
  } seq_state_t;

  typedef struct packed {
    logic rst_n_auto;
    logic reset_n;
    logic sw_clk;
  } seq_out_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Moore decode; the clock gate is only ever open once both resets are released.
  function automatic seq_out_t state_outputs(input seq_state_t s);
    seq_out_t o;
    o = '0;
    case (s)
      ST_WAIT_RST, ST_ASIC_RST: o = '{rst_n_auto: 1'b1, reset_n: 1'b0, sw_clk: 1'b0};
      ST_WAIT_CLK, ST_HALT:     o = '{rst_n_auto: 1'b1, reset_n: 1'b1, sw_clk: 1'b0};
      ST_RUN:                   o = '{rst_n_auto: 1'b1, reset_n: 1'b1, sw_clk: 1'b1};
      default:                  o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single push-button conditioner: 2-flop synchronizer, stability counter and
// a one-cycle press pulse on each accepted rising level.
module sw_debounce
  import sw_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic I_clk_src,
  input  logic I_rst_n,
  input  logic I_sw_raw,
  output logic O_level,
  output logic O_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q;
  logic             level;
  logic             press;
  logic [CNT_W-1:0] cnt;

  // The level flips on the DEBOUNCE_CYC-th consecutive disagreeing cycle.
  always_ff @(posedge I_clk_src or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync_q <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], I_sw_raw};
      press  <= 1'b0;
      if (sync_q[1] != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_q[1];
          press <= sync_q[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign O_level = level;
  assign O_press = press;

endmodule

// File: rtl/sw_reset_clk_seq.sv
// Bring-up sequencer: debounced buttons step board reset, ASIC reset and the
// ASIC clock gate in order; all outputs come straight from flops.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   IDLE     | after power-on, everything held in reset
//   AUTO_RST | bridge reset pulse running (AUTO_RST_CYC cycles)
//   WAIT_RST | bridge released, waiting for SW_C
//   ASIC_RST | ASIC reset pulse running (ASIC_RST_CYC cycles)
//   WAIT_CLK | ASIC out of reset, clocks gated, waiting for SW_N
//   RUN      | clocks passing to the ASIC
//   HALT     | clocks gated again by SW_N
module sw_reset_clk_seq
  import sw_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int AUTO_RST_CYC = AUTO_RST_CYC_DEF,
  parameter int ASIC_RST_CYC = ASIC_RST_CYC_DEF
) (
  input  logic       I_clk_src,
  input  logic       I_rst_n,
  input  logic       I_SW_S,
  input  logic       I_SW_C,
  input  logic       I_SW_N,
  output logic       O_rst_n_auto,
  output logic       O_reset_n,
  output logic       O_SW_clk,
  output logic [2:0] O_state
);

  localparam int TMR_MAX = max_int(AUTO_RST_CYC, ASIC_RST_CYC);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] AUTO_LOAD = TMR_W'(AUTO_RST_CYC - 1);
  localparam logic [TMR_W-1:0] ASIC_LOAD = TMR_W'(ASIC_RST_CYC - 1);

  logic [2:0] sw_raw;
  logic [2:0] sw_press;
  logic [2:0] sw_level_unused;

  assign sw_raw = {I_SW_N, I_SW_C, I_SW_S};

  for (genvar i = 0; i < 3; i++) begin : g_btn
    sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
      .I_clk_src (I_clk_src),
      .I_rst_n   (I_rst_n),
      .I_sw_raw  (sw_raw[i]),
      .O_level   (sw_level_unused[i]),
      .O_press   (sw_press[i])
    );
  end

  logic press_s, press_c, press_n;
  assign press_s = sw_press[0];
  assign press_c = sw_press[1];
  assign press_n = sw_press[2];

  seq_state_t       state, state_next;
  logic [TMR_W-1:0] tmr, tmr_next;
  seq_out_t         outs;

  always_ff @(posedge I_clk_src or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state <= ST_IDLE;
      tmr   <= '0;
      outs  <= '0;
    end else begin
      state <= state_next;
      tmr   <= tmr_next;
      outs  <= state_outputs(state_next);
    end
  end

  // Priority S > C > N falls out of the if/else order; losers are dropped.
  always_comb begin
    state_next = state;
    tmr_next   = tmr;
    if (press_s) begin
      state_next = ST_AUTO_RST;
      tmr_next   = AUTO_LOAD;
    end else if (press_c && state != ST_IDLE && state != ST_AUTO_RST) begin
      state_next = ST_ASIC_RST;
      tmr_next   = ASIC_LOAD;
    end else begin
      case (state)
        ST_IDLE: state_next = ST_IDLE;
        ST_AUTO_RST: begin
          if (tmr == '0) state_next = ST_WAIT_RST;
          else           tmr_next   = tmr - 1'b1;
        end
        ST_WAIT_RST: state_next = ST_WAIT_RST;
        ST_ASIC_RST: begin
          if (tmr == '0) state_next = ST_WAIT_CLK;
          else           tmr_next   = tmr - 1'b1;
        end
        ST_WAIT_CLK: if (press_n) state_next = ST_RUN;
        ST_RUN:      if (press_n) state_next = ST_HALT;
        ST_HALT:     if (press_n) state_next = ST_RUN;
        default:     state_next = ST_IDLE;
      endcase
    end
  end

  assign O_rst_n_auto = outs.rst_n_auto;
  assign O_reset_n    = outs.reset_n;
  assign O_SW_clk     = outs.sw_clk;
  assign O_state      = state;

endmodule
